// File: rtl/mem_pkg.sv
// Shared data-memory types for the MEM-stage store path.
// Entry layout for the posted-write buffer plus the byte-lane merge used on drain.
package mem_pkg;
   localparam int DM_AW = 10;
   localparam int BE_W  = 4;

   typedef struct packed {
      logic [DM_AW-1:0] addr;
      logic [31:0]      data;
      logic [BE_W-1:0]  be;
   } sb_entry_t;

   // Take the enabled bytes from new_w, keep the rest of old_w.
   function automatic logic [31:0] byte_merge(input logic [31:0]     old_w,
                                              input logic [31:0]     new_w,
                                              input logic [BE_W-1:0] be);
      logic [31:0] r;
      r = old_w;
      for (int k = 0; k < BE_W; k++)
         if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
      return r;
   endfunction
endpackage

// File: rtl/sb_forward.sv
// Store-to-load forwarding: per byte lane, pick the youngest valid buffered
// store hitting ld_addr with that byte enabled, else fall back to memory.
module sb_forward
   import mem_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int AW    = 10,
   localparam int PW    = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] ent,
   input  logic [DEPTH-1:0]      valid,
   input  logic [PW-1:0]         head,
   input  logic [AW-1:0]         ld_addr,
   input  logic [31:0]           dm_rdata,
   output logic [31:0]           ld_data
);
   logic [DEPTH-1:0] hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign hit[i] = valid[i] && (ent[i].addr == DM_AW'(ld_addr));
   end

   // Walk oldest -> youngest so the last hit wins.
   for (genvar k = 0; k < BE_W; k++) begin : g_lane
      logic [7:0] b;
      always_comb begin
         logic [PW-1:0] idx;
         idx = '0;
         b   = dm_rdata[8*k +: 8];
         for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (hit[idx] && ent[idx].be[k]) b = ent[idx].data[8*k +: 8];
         end
      end
      assign ld_data[8*k +: 8] = b;
   end
endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of the single-port data memory.
// Stores enter in one cycle; entries drain read-merge-write whenever no load holds the port.
module dm_store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [AW-1:0]              st_addr,
   input  logic [31:0]                st_data,
   input  logic [3:0]                 st_be,
   output logic                       st_ready,
   input  logic                       ld_valid,
   input  logic [AW-1:0]              ld_addr,
   output logic [31:0]                ld_data,
   output logic [AW-1:0]              dm_a,
   output logic [31:0]                dm_wdata,
   output logic                       dm_we,
   input  logic [31:0]                dm_rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   sb_entry_t [DEPTH-1:0] ent;
   sb_entry_t             hd;
   logic [PW-1:0]         head, tail;
   logic [DEPTH-1:0]      valid;
   logic                  accept, drain;

   assign empty    = (count == '0);
   assign st_ready = (count != CW'(DEPTH));
   assign accept   = st_valid && st_ready;
   assign drain    = !empty && !ld_valid && !reset;
   assign hd       = ent[head];

   // A load owns the port; otherwise it points at the head entry.
   assign dm_a     = ld_valid ? ld_addr : AW'(hd.addr);
   assign dm_we    = drain;
   assign dm_wdata = byte_merge(dm_rdata, hd.data, hd.be);

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (accept) tail <= tail + 1'b1;
         if (drain)  head <= head + 1'b1;
         count <= count + CW'(accept) - CW'(drain);
      end
   end

   // Payload needs no reset; occupancy is tracked by head/count.
   always_ff @(posedge clk) begin
      if (!reset && accept) ent[tail] <= '{addr: DM_AW'(st_addr), data: st_data, be: st_be};
   end

   // Entry j is live when its distance from head is below count.
   for (genvar j = 0; j < DEPTH; j++) begin : g_valid
      logic [PW-1:0] off;
      assign off      = PW'(j) - head;
      assign valid[j] = CW'(off) < count;
   end

   sb_forward #(.DEPTH(DEPTH), .AW(AW)) u_fwd (
      .ent      (ent),
      .valid    (valid),
      .head     (head),
      .ld_addr  (ld_addr),
      .dm_rdata (dm_rdata),
      .ld_data  (ld_data)
   );
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a behavioural combinational-read data memory.
module tb_dm_store_buffer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        st_valid = 1'b0;
   logic [9:0]  st_addr = '0;
   logic [31:0] st_data = '0;
   logic [3:0]  st_be = '0;
   logic        st_ready;
   logic        ld_valid = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [31:0] ld_data;
   logic [9:0]  dm_a;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic [31:0] dm_rdata;
   logic [2:0]  count;
   logic        empty;

   logic [31:0] mem [0:1023];
   logic [9:0]  wlog [0:63];
   int          wn = 0;
   logic        clr = 1'b0, pre_we = 1'b0, allow_both = 1'b0;
   logic [9:0]  pre_a = '0;
   logic [31:0] pre_d = '0;
   int          pass_cnt = 0, total_cnt = 0;

   dm_store_buffer #(.DEPTH(4), .AW(10)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .dm_a(dm_a), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_a];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (pre_we) begin
         mem[pre_a] <= pre_d;
      end else if (dm_we) begin
         mem[dm_a] <= dm_wdata;
      end
      if (dm_we) begin
         wlog[wn % 64] <= dm_a;
         wn <= wn + 1;
      end
      if (!reset && !allow_both && st_valid && ld_valid)
         $error("store and load requested in the same cycle");
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      int w0;
      reset = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b want 1", st_ready); else pass_cnt++;
      total_cnt++; if (dm_we !== 1'b0) $display("FAIL reset_dm_we: got %b want 0", dm_we); else pass_cnt++;
      w0 = wn;
      repeat (4) tick();
      total_cnt++; if (wn !== w0) $display("FAIL idle_writes: got %0d want %0d", wn, w0); else pass_cnt++;
      total_cnt++; if (mem[5] !== 32'h0) $display("FAIL idle_mem5: got %h want 00000000", mem[5]); else pass_cnt++;
   endtask

   task automatic test_partial_drain();
      preload(10'd5, 32'h11223344);
      st_valid = 1'b1; st_addr = 10'd5; st_data = 32'h0000AA00; st_be = 4'b0010;
      #1;
      total_cnt++; if (dm_we !== 1'b0) $display("FAIL partial_accept_we: got %b want 0", dm_we); else pass_cnt++;
      tick();
      st_valid = 1'b0;
      #1;
      total_cnt++; if (dm_we !== 1'b1) $display("FAIL partial_drain_we: got %b want 1", dm_we); else pass_cnt++;
      total_cnt++; if (dm_a !== 10'd5) $display("FAIL partial_drain_a: got %0d want 5", dm_a); else pass_cnt++;
      total_cnt++; if (dm_wdata !== 32'h1122AA44) $display("FAIL partial_wdata: got %h want 1122aa44", dm_wdata); else pass_cnt++;
      tick();
      total_cnt++; if (empty !== 1'b1) $display("FAIL partial_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (mem[5] !== 32'h1122AA44) $display("FAIL partial_mem5: got %h want 1122aa44", mem[5]); else pass_cnt++;
   endtask

   task automatic test_forward_priority();
      int n;
      st_valid = 1'b1; st_addr = 10'd7; st_data = 32'hDEADBEEF; st_be = 4'b1111;
      tick();
      st_data = 32'h00000055; st_be = 4'b0001;
      tick();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 10'd7;
      #1;
      total_cnt++; if (ld_data !== 32'hDEADBE55) $display("FAIL fwd_ld_data: got %h want deadbe55", ld_data); else pass_cnt++;
      total_cnt++; if (dm_we !== 1'b0) $display("FAIL fwd_load_we: got %b want 0", dm_we); else pass_cnt++;
      total_cnt++; if (dm_a !== 10'd7) $display("FAIL fwd_load_a: got %0d want 7", dm_a); else pass_cnt++;
      tick();
      ld_valid = 1'b0;
      n = 0;
      while (!empty && n < 20) begin tick(); n++; end
      total_cnt++; if (empty !== 1'b1) $display("FAIL fwd_drain_timeout: empty %b want 1", empty); else pass_cnt++;
      total_cnt++; if (mem[7] !== 32'hDEADBE55) $display("FAIL fwd_mem7: got %h want deadbe55", mem[7]); else pass_cnt++;
   endtask

   task automatic test_full_wrap();
      int n, w0;
      for (int i = 0; i < 8; i++) preload(10'(i), 32'hFFFFFFFF);
      allow_both = 1'b1; ld_valid = 1'b1; ld_addr = 10'd2;
      for (int i = 0; i < 4; i++) begin
         st_valid = 1'b1; st_addr = 10'(i); st_data = 32'(i); st_be = 4'b1111;
         #1;
         total_cnt++; if (st_ready !== 1'b1) $display("FAIL full_fill_ready%0d: got %b want 1", i, st_ready); else pass_cnt++;
         tick();
      end
      st_valid = 1'b0;
      #1;
      total_cnt++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else pass_cnt++;
      total_cnt++; if (st_ready !== 1'b0) $display("FAIL full_st_ready: got %b want 0", st_ready); else pass_cnt++;
      total_cnt++; if (ld_data !== 32'h00000002) $display("FAIL full_fwd: got %h want 00000002", ld_data); else pass_cnt++;
      total_cnt++; if (dm_we !== 1'b0) $display("FAIL full_load_we: got %b want 0", dm_we); else pass_cnt++;
      allow_both = 1'b0; ld_valid = 1'b0;
      st_valid = 1'b1; st_addr = 10'd4; st_data = 32'd4;
      w0 = wn;
      #1;
      total_cnt++; if (dm_we !== 1'b1) $display("FAIL full_drain_we: got %b want 1", dm_we); else pass_cnt++;
      total_cnt++; if (dm_a !== 10'd0) $display("FAIL full_drain_a: got %0d want 0", dm_a); else pass_cnt++;
      total_cnt++; if (st_ready !== 1'b0) $display("FAIL full_ready_same_cycle: got %b want 0", st_ready); else pass_cnt++;
      tick();
      total_cnt++; if (st_ready !== 1'b1) $display("FAIL full_ready_next: got %b want 1", st_ready); else pass_cnt++;
      total_cnt++; if (count !== 3'd3) $display("FAIL full_count_after: got %0d want 3", count); else pass_cnt++;
      for (int i = 4; i < 8; i++) begin
         st_addr = 10'(i); st_data = 32'(i);
         tick();
      end
      st_valid = 1'b0;
      n = 0;
      while (!empty && n < 20) begin tick(); n++; end
      total_cnt++; if (wn - w0 !== 8) $display("FAIL wrap_writes: got %0d want 8", wn - w0); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if (mem[i] !== 32'(i) || wlog[(w0 + i) % 64] !== 10'(i))
            $display("FAIL wrap_order%0d: mem %h addr %0d want data %h addr %0d", i, mem[i], wlog[(w0 + i) % 64], i, i);
         else pass_cnt++;
      end
   endtask

   task automatic test_same_addr_chain();
      int n;
      preload(10'd3, 32'h0);
      st_valid = 1'b1; st_addr = 10'd3;
      st_data = 32'h00000001; st_be = 4'b0001; tick();
      st_data = 32'h00020000; st_be = 4'b0100; tick();
      st_data = 32'h03000000; st_be = 4'b1000; tick();
      st_valid = 1'b0;
      n = 0;
      while (!empty && n < 20) begin tick(); n++; end
      total_cnt++; if (mem[3] !== 32'h03020001) $display("FAIL chain_mem3: got %h want 03020001", mem[3]); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int w0;
      allow_both = 1'b1; ld_valid = 1'b1; ld_addr = 10'd100;
      for (int i = 10; i < 13; i++) begin
         st_valid = 1'b1; st_addr = 10'(i); st_data = 32'hA5A5A5A5; st_be = 4'b1111;
         tick();
      end
      st_valid = 1'b0;
      #1;
      total_cnt++; if (count !== 3'd3) $display("FAIL rmid_count_before: got %0d want 3", count); else pass_cnt++;
      allow_both = 1'b0; ld_valid = 1'b0; reset = 1'b1;
      #1;
      total_cnt++; if (dm_we !== 1'b0) $display("FAIL rmid_we_in_reset: got %b want 0", dm_we); else pass_cnt++;
      w0 = wn;
      tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (count !== 3'd0) $display("FAIL rmid_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL rmid_empty: got %b want 1", empty); else pass_cnt++;
      repeat (4) tick();
      total_cnt++; if (wn !== w0) $display("FAIL rmid_writes: got %0d want %0d", wn, w0); else pass_cnt++;
      for (int i = 10; i < 13; i++) begin
         total_cnt++; if (mem[i] !== 32'h0) $display("FAIL rmid_mem%0d: got %h want 00000000", i, mem[i]); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_partial_drain();
      test_forward_priority();
      test_full_wrap();
      test_same_addr_chain();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
